// File: rtl/apb_ram_param.sv
// Parameterised APB slave RAM with byte-lane strobes, error response and abort handling.
// Define APB_RAM_WAIT_EN to build WAIT_CYCLES access-phase wait states into every transfer.
module apb_ram_param #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);
    localparam int NBYTES = DATA_W / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'((1 << LSB) - 1);

    if (DATA_W < 8 || (DATA_W % 8) != 0 || DEPTH < 2 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_params
        $error("apb_ram_param: unsupported parameter set");
    end

`ifdef APB_RAM_WAIT_EN
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
    logic [3:0] cnt, cnt_next;
`else
    typedef enum logic [1:0] {IDLE, ACCESS} state_t;
`endif

    state_t state, state_next;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] bus_word;
    logic              bus_err;
    logic              setup;
    logic [IDX_W-1:0]  idx_q, idx_sel;
    logic              wr_q, err_q, wr_sel, err_sel;
    logic [DATA_W-1:0] load_data, prdata_next;
    logic              pready_next, pslverr_next;
    logic              load_out, mem_we;

    assign setup    = psel && !penable;
    assign bus_word = paddr >> LSB;
    assign bus_err  = (|(paddr & LANE_MASK)) || (bus_word >= ADDR_W'(DEPTH));

    // In IDLE the response is built from the live setup-phase bus; later it comes from the latched copy.
    assign idx_sel   = (state == IDLE) ? bus_word[IDX_W-1:0] : idx_q;
    assign wr_sel    = (state == IDLE) ? pwrite : wr_q;
    assign err_sel   = (state == IDLE) ? bus_err : err_q;
    assign load_data = (wr_sel || err_sel) ? '0 : mem[idx_sel];

    always_comb begin
        state_next   = state;
        prdata_next  = prdata;
        pready_next  = pready;
        pslverr_next = pslverr;
        load_out     = 1'b0;
        mem_we       = 1'b0;
`ifdef APB_RAM_WAIT_EN
        cnt_next     = cnt;
`endif
        case (state)
            IDLE: begin
                if (setup) begin
`ifdef APB_RAM_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES);
                    end else begin
                        state_next = ACCESS;
                        load_out   = 1'b1;
                    end
`else
                    state_next = ACCESS;
                    load_out   = 1'b1;
`endif
                end
            end
`ifdef APB_RAM_WAIT_EN
            WAIT: begin
                if (!psel) begin
                    state_next   = IDLE;
                    pready_next  = 1'b0;
                    pslverr_next = 1'b0;
                    prdata_next  = '0;
                    cnt_next     = '0;
                end else if (penable) begin
                    if (cnt == 4'd1) begin
                        state_next = ACCESS;
                        load_out   = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
                end
            end
`endif
            ACCESS: begin
                // Dropping psel here is an abort: the transfer ends without touching memory.
                mem_we       = psel && penable && wr_q && !err_q;
                state_next   = IDLE;
                pready_next  = 1'b0;
                pslverr_next = 1'b0;
                prdata_next  = '0;
            end
            default: state_next = IDLE;
        endcase

        if (load_out) begin
            pready_next  = 1'b1;
            pslverr_next = err_sel;
            prdata_next  = load_data;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef APB_RAM_WAIT_EN
            cnt     <= '0;
`endif
        end else begin
            state   <= state_next;
            prdata  <= prdata_next;
            pready  <= pready_next;
            pslverr <= pslverr_next;
`ifdef APB_RAM_WAIT_EN
            cnt     <= cnt_next;
`endif
            if (state == IDLE && setup) begin
                idx_q <= bus_word[IDX_W-1:0];
                wr_q  <= pwrite;
                err_q <= bus_err;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (pstrb[b]) begin
                    mem[idx_q][b*8 +: 8] <= pwdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_ram_param.sv
// Self-checking bench for apb_ram_param: directed vector table, hand-built abort/reset sequences,
// and randomized transfers checked against an array-based memory model.
`timescale 1ns/1ps
module tb_apb_ram_param;
    localparam int DATA_W      = 32;
    localparam int DEPTH       = 32;
    localparam int ADDR_W      = 32;
    localparam int WAIT_CYCLES = 2;
    localparam int IDX_W       = $clog2(DEPTH);
`ifdef APB_RAM_WAIT_EN
    localparam int EXP_WAITS = WAIT_CYCLES;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [20];

    apb_ram_param #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .pstrb  (pstrb),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One complete transfer starting at the next falling edge; returns on the falling edge where pready is seen.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, output logic [31:0] rdata,
                                 output logic slverr, output int waits);
        @(negedge pclk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        @(negedge pclk);
        penable = 1'b1;
        waits   = 0;
        for (int n = 0; n < 20 && pready !== 1'b1; n++) begin
            waits++;
            @(negedge pclk);
        end
        if (pready !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL pready_timeout: got pready=%b, expected 1 within 20 cycles", pready);
        end
        rdata  = prdata;
        slverr = pslverr;
    endtask

    task automatic idleBus();
        @(negedge pclk);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    function automatic logic modelErr(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
    endfunction

    task automatic modelWrite(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        if (!modelErr(addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_mem[IDX_W'(addr >> 2)][b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    task automatic doChecked(input string name, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] rd, exp_rd;
        logic        se, exp_se;
        int          w;
        exp_se = modelErr(addr);
        exp_rd = (wr || exp_se) ? 32'h0 : model_mem[IDX_W'(addr >> 2)];
        applyStimulus(wr, addr, wdata, strb, rd, se, w);
        checkOutput({name, "_rdata"}, rd, exp_rd);
        checkOutput({name, "_pslverr"}, 32'(se), 32'(exp_se));
        checkOutput({name, "_waits"}, 32'(w), 32'(EXP_WAITS));
        if (wr) modelWrite(addr, wdata, strb);
    endtask

    logic [31:0] rd, a;
    logic        se, rwr;
    int          w, sel;

    initial begin
        vecs[0]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b1, 32'h04, 32'h000000AA, 4'h1, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        vecs[4]  = '{1'b0, 32'h80, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vecs[5]  = '{1'b1, 32'h06, 32'h11223344, 4'hF, 32'h00000000, 1'b1};
        vecs[6]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        vecs[7]  = '{1'b1, 32'h08, 32'h12345678, 4'hF, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h12345678, 1'b0};
        vecs[9]  = '{1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h12345678, 1'b0};
        vecs[11] = '{1'b1, 32'h0C, 32'hA5A5A5A5, 4'hA, 32'h00000000, 1'b0};
        vecs[12] = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'hA500A500, 1'b0};
        vecs[13] = '{1'b0, 32'h7C, 32'h0,        4'h0, 32'h00000000, 1'b0};
        vecs[14] = '{1'b1, 32'h7C, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0};
        vecs[15] = '{1'b0, 32'h7C, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[16] = '{1'b1, 32'h80, 32'h55555555, 4'hF, 32'h00000000, 1'b1};
        vecs[17] = '{1'b0, 32'h7C, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[18] = '{1'b1, 32'h05, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1};
        vecs[19] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0};

        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        modelClear();
        repeat (3) @(negedge pclk);
        checkOutput("reset_pready", 32'(pready), 32'h0);
        checkOutput("reset_pslverr", 32'(pslverr), 32'h0);
        checkOutput("reset_prdata", prdata, 32'h0);
        presetn = 1'b1;

        // Vectors run back-to-back with no idle cycle between transfers.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, se, w);
            checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_pslverr", i), 32'(se), 32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_waits", i), 32'(w), 32'(EXP_WAITS));
            if (vecs[i].wr) modelWrite(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
        end
        idleBus();

        // penable without a preceding setup cycle must be ignored.
        @(negedge pclk);
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 32'h04;
        @(negedge pclk);
        checkOutput("stray_penable_pready1", 32'(pready), 32'h0);
        @(negedge pclk);
        checkOutput("stray_penable_pready2", 32'(pready), 32'h0);
        idleBus();
        doChecked("after_stray_rd04", 1'b0, 32'h04, 32'h0, 4'h0);
        idleBus();

        // Abort a write to 0x10 by dropping psel before the completion edge.
        @(negedge pclk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h10;
        pwdata  = 32'hFFFFFFFF;
        pstrb   = 4'hF;
`ifdef APB_RAM_WAIT_EN
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        checkOutput("abort_wait_pready", 32'(pready), 32'h0);
`else
        @(negedge pclk);
        checkOutput("abort_access_pready", 32'(pready), 32'h1);
`endif
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        checkOutput("abort_pready_cleared", 32'(pready), 32'h0);
        checkOutput("abort_pslverr_cleared", 32'(pslverr), 32'h0);
        doChecked("abort_rd10", 1'b0, 32'h10, 32'h0, 4'h0);
        idleBus();

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = ($urandom % DEPTH) * 4;
            else if (sel == 7) a = ($urandom % DEPTH) * 4 + $urandom_range(1, 3);
            else if (sel == 8) a = (DEPTH + $urandom_range(0, 100)) * 4;
            else               a = $urandom;
            rwr = 1'($urandom);
            doChecked($sformatf("rand%0d", i), rwr, a, $urandom, 4'($urandom));
            if ($urandom_range(0, 1) == 1) idleBus();
        end
        idleBus();

        // Reset asserted while an error response is on the bus.
        applyStimulus(1'b0, 32'h80, 32'h0, 4'h0, rd, se, w);
        checkOutput("prereset_pready", 32'(pready), 32'h1);
        checkOutput("prereset_pslverr", 32'(se), 32'h1);
        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        #1;
        checkOutput("midreset_pready", 32'(pready), 32'h0);
        checkOutput("midreset_pslverr", 32'(pslverr), 32'h0);
        checkOutput("midreset_prdata", prdata, 32'h0);
        @(negedge pclk);
        presetn = 1'b1;
        modelClear();
        doChecked("post_reset_rd04", 1'b0, 32'h04, 32'h0, 4'h0);
        doChecked("post_reset_rd7c", 1'b0, 32'h7C, 32'h0, 4'h0);
        idleBus();
        repeat (2) @(negedge pclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
